// File: rtl/cn_bank_ctrl.sv
// Sequencer and round-robin two-port arbiter for a bank of CN (change/no-change) cells.
// Each request becomes per-bit C/N vectors; the result is checked and the op retried on mismatch.
module cn_bank_ctrl #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [1:0]       op0,
    input  logic [1:0]       op1,
    input  logic [WIDTH-1:0] mask0,
    input  logic [WIDTH-1:0] mask1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] cell_stall,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             err,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] cn_c,
    output logic [WIDTH-1:0] cn_n,
    output logic [WIDTH-1:0] q,
    output logic             busy
);

    localparam int unsigned RW = 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_CLEAR  = 2'b01;
    localparam logic [1:0] OP_TOGGLE = 2'b10;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_id;
    logic             r_last;
    logic [WIDTH-1:0] r_target;
    logic [RW-1:0]    r_retry;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_cn_c;
    logic [WIDTH-1:0] r_cn_n;
    logic [WIDTH-1:0] r_rdata;
    logic             r_err;
    logic             r_gnt0;
    logic             r_gnt1;
    logic             r_done0;
    logic             r_done1;
    logic             r_busy;

    logic             w_grant;
    logic             w_sel;
    logic [1:0]       w_op;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_data;
    logic [WIDTH-1:0] w_tgt_grant;
    logic [WIDTH-1:0] w_target_nxt;
    logic [RW-1:0]    w_retry_nxt;
    logic             w_finish;
    logic             w_fail;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_eff_n;
    logic [WIDTH-1:0] w_q_nxt;

    // Next-state, grant selection and bank update logic
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_retry_nxt = r_retry;
        w_finish    = 1'b0;
        w_fail      = 1'b0;
        w_sel       = (req0 && req1) ? ~r_last : req1;
        w_op        = w_sel ? op1   : op0;
        w_mask      = w_sel ? mask1 : mask0;
        w_data      = w_sel ? data1 : data0;

        case (w_op)
            OP_WRITE:  w_tgt_grant = (r_q & ~w_mask) | (w_data & w_mask);
            OP_CLEAR:  w_tgt_grant = r_q & ~w_mask;
            OP_TOGGLE: w_tgt_grant = r_q ^ w_mask;
            default:   w_tgt_grant = r_q;
        endcase

        case (r_state)
            S_IDLE: begin
                if (req0 || req1) begin
                    w_grant     = 1'b1;
                    w_retry_nxt = '0;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: w_state_nxt = S_CHECK;
            S_CHECK: begin
                if (r_q == r_target) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (r_retry < RW'(MAX_RETRY)) begin
                    w_retry_nxt = r_retry + RW'(1);
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_finish    = 1'b1;
                    w_fail      = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_target_nxt = w_grant ? w_tgt_grant : r_target;
        w_diff       = r_q ^ w_target_nxt;
        // cn_n is zero outside ISSUE, so the bank only moves on the edge closing ISSUE
        w_eff_n      = r_cn_n & ~cell_stall;
        w_q_nxt      = (r_q & ~w_eff_n) | (w_eff_n & r_cn_c & ~r_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_id     <= 1'b0;
            r_last   <= 1'b1;
            r_target <= '0;
            r_retry  <= '0;
            r_q      <= '0;
            r_cn_c   <= '0;
            r_cn_n   <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_q      <= w_q_nxt;
            r_target <= w_target_nxt;
            r_retry  <= w_retry_nxt;
            r_cn_n   <= (w_state_nxt == S_ISSUE) ? w_diff : '0;
            r_cn_c   <= (w_state_nxt == S_ISSUE) ? (w_diff & w_target_nxt) : '0;
            r_gnt0   <= w_grant & ~w_sel;
            r_gnt1   <= w_grant & w_sel;
            r_done0  <= w_finish & ~r_id;
            r_done1  <= w_finish & r_id;
            r_busy   <= (w_state_nxt != S_IDLE);
            if (w_grant) begin
                r_id   <= w_sel;
                r_last <= w_sel;
            end
            if (w_finish) begin
                r_rdata <= r_q;
                r_err   <= w_fail;
            end
        end
    end

    assign gnt0  = r_gnt0;
    assign gnt1  = r_gnt1;
    assign done0 = r_done0;
    assign done1 = r_done1;
    assign err   = r_err;
    assign rdata = r_rdata;
    assign cn_c  = r_cn_c;
    assign cn_n  = r_cn_n;
    assign q     = r_q;
    assign busy  = r_busy;

endmodule

// File: tb/tb_cn_bank_ctrl.sv
// Bench for cn_bank_ctrl: op-level reference model checked every cycle, plus directed literal checks.
module tb_cn_bank_ctrl;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned MAX_RETRY = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             req0, req1;
    logic [1:0]       op0, op1;
    logic [WIDTH-1:0] mask0, mask1, data0, data1, cell_stall;
    logic             gnt0, gnt1, done0, done1, err, busy;
    logic [WIDTH-1:0] rdata, cn_c, cn_n, q;

    cn_bank_ctrl #(.WIDTH(WIDTH), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .mask0(mask0), .mask1(mask1), .data0(data0), .data1(data1),
        .cell_stall(cell_stall),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err(err),
        .rdata(rdata), .cn_c(cn_c), .cn_n(cn_n), .q(q), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected outputs per cycle, derived op by op
    logic             e_gnt0, e_gnt1, e_done0, e_done1, e_err, e_busy;
    logic [WIDTH-1:0] e_rdata, e_cn_n, e_cn_c;
    logic [WIDTH-1:0] m_q;
    logic             m_last;
    int               m_issues = 0;
    bit               cmp_en = 0;

    task automatic m_clear();
        e_gnt0 = 0; e_gnt1 = 0; e_done0 = 0; e_done1 = 0; e_err = 0; e_busy = 0;
        e_rdata = '0; e_cn_n = '0; e_cn_c = '0;
        m_q = '0; m_last = 1'b1;
    endtask

    task automatic m_serve();
        logic             id;
        logic [1:0]       op;
        logic [WIDTH-1:0] mk, dt, tgt, diff, eff;
        logic             fail;
        int               tries;
        id = (req0 && req1) ? !m_last : req1;
        m_last = id;
        op = id ? op1 : op0;
        mk = id ? mask1 : mask0;
        dt = id ? data1 : data0;
        case (op)
            2'b00:   tgt = (m_q & ~mk) | (dt & mk);
            2'b01:   tgt = m_q & ~mk;
            2'b10:   tgt = m_q ^ mk;
            default: tgt = m_q;
        endcase
        tries = 0;
        fail = 0;
        forever begin
            diff = m_q ^ tgt;
            e_gnt0 = (tries == 0) && !id;
            e_gnt1 = (tries == 0) && id;
            e_busy = 1; e_cn_n = diff; e_cn_c = diff & tgt;
            e_done0 = 0; e_done1 = 0;
            @(posedge clk);
            if (reset) begin m_clear(); return; end
            eff = diff & ~cell_stall;
            m_q = (m_q & ~eff) | (tgt & eff);
            m_issues++;
            e_gnt0 = 0; e_gnt1 = 0; e_cn_n = '0; e_cn_c = '0;
            @(posedge clk);
            if (reset) begin m_clear(); return; end
            if (m_q == tgt) break;
            if (tries < int'(MAX_RETRY)) begin tries++; continue; end
            fail = 1;
            break;
        end
        e_done0 = !id; e_done1 = id; e_err = fail; e_rdata = m_q;
        @(posedge clk);
        if (reset) begin m_clear(); return; end
        e_done0 = 0; e_done1 = 0; e_busy = 0;
    endtask

    initial begin : model
        m_clear();
        forever begin
            @(posedge clk);
            if (reset) begin m_clear(); continue; end
            e_gnt0 = 0; e_gnt1 = 0; e_done0 = 0; e_done1 = 0; e_busy = 0;
            e_cn_n = '0; e_cn_c = '0;
            if (req0 || req1) m_serve();
        end
    end

    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            chk("gnt0", 32'(gnt0), 32'(e_gnt0));
            chk("gnt1", 32'(gnt1), 32'(e_gnt1));
            chk("done0", 32'(done0), 32'(e_done0));
            chk("done1", 32'(done1), 32'(e_done1));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("q", 32'(q), 32'(m_q));
            chk("cn_n", 32'(cn_n), 32'(e_cn_n));
            chk("cn_c", 32'(cn_c), 32'(e_cn_c));
            if (e_done0 || e_done1) begin
                chk("err", 32'(err), 32'(e_err));
                chk("rdata", 32'(rdata), 32'(e_rdata));
            end
        end
    end

    // Requester driver and observation record
    logic [WIDTH-1:0] d_rdata [2];
    logic             d_err   [2];
    int               d_lat   [2];
    int               g_cyc   [2];
    logic [WIDTH-1:0] g_cn_n, g_cn_c;
    int               n_issue;
    int               gq [$];

    task automatic set_op(input bit id, input logic [1:0] op, input logic [WIDTH-1:0] mk,
                          input logic [WIDTH-1:0] dt);
        if (id) begin op1 = op; mask1 = mk; data1 = dt; end
        else    begin op0 = op; mask0 = mk; data0 = dt; end
    endtask

    task automatic run(input bit u0, input bit u1, input int rel_at);
        int cyc = 0;
        n_issue = 0;
        gq.delete();
        d_lat[0] = -1; d_lat[1] = -1; g_cyc[0] = -1; g_cyc[1] = -1;
        @(negedge clk);
        req0 = u0; req1 = u1;
        while ((req0 || req1) && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (cn_n != '0) n_issue++;
            if (rel_at > 0 && n_issue == rel_at) cell_stall = '0;
            if (gnt0) begin gq.push_back(0); g_cyc[0] = cyc; g_cn_n = cn_n; g_cn_c = cn_c; end
            if (gnt1) begin gq.push_back(1); g_cyc[1] = cyc; end
            if (done0 && req0) begin req0 = 0; d_err[0] = err; d_rdata[0] = rdata; d_lat[0] = cyc; end
            if (done1 && req1) begin req1 = 0; d_err[1] = err; d_rdata[1] = rdata; d_lat[1] = cyc; end
        end
        if (req0 || req1) begin
            chk("timeout_waiting_done", 32'd1, 32'd0);
            req0 = 0; req1 = 0;
        end
    endtask

    initial begin : stim
        int iss0;
        int cyc;
        bit seen;
        reset = 1;
        req0 = 0; req1 = 0; op0 = '0; op1 = '0;
        mask0 = '0; mask1 = '0; data0 = '0; data1 = '0; cell_stall = '0;
        repeat (2) @(negedge clk);
        chk("rst_q", 32'(q), 32'h00);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_cn_n", 32'(cn_n), 32'h00);
        chk("rst_rdata", 32'(rdata), 32'h00);
        chk("rst_err", 32'(err), 32'h0);
        #1 reset = 0;
        cmp_en = 1;

        // WRITE A5 from req0
        set_op(0, 2'b00, 8'hFF, 8'hA5);
        run(1, 0, 0);
        chk("w_gnt_cycle", g_cyc[0], 1);
        chk("w_cn_n", 32'(g_cn_n), 32'hA5);
        chk("w_cn_c", 32'(g_cn_c), 32'hA5);
        chk("w_lat", d_lat[0], 3);
        chk("w_rdata", 32'(d_rdata[0]), 32'hA5);
        chk("w_err", 32'(d_err[0]), 32'h0);
        chk("w_model_q", 32'(m_q), 32'hA5);

        // TOGGLE 0F from req1, then CLEAR F0
        set_op(1, 2'b10, 8'h0F, 8'h00);
        run(0, 1, 0);
        chk("t_lat", d_lat[1], 3);
        chk("t_rdata", 32'(d_rdata[1]), 32'hAA);
        chk("t_err", 32'(d_err[1]), 32'h0);
        set_op(1, 2'b01, 8'hF0, 8'h00);
        run(0, 1, 0);
        chk("c_rdata", 32'(d_rdata[1]), 32'h0A);
        chk("c_model_q", 32'(m_q), 32'h0A);

        // Simultaneous requests
        set_op(0, 2'b00, 8'hFF, 8'h11);
        set_op(1, 2'b00, 8'hFF, 8'h22);
        run(1, 1, 0);
        chk("arb_ngnt", gq.size(), 2);
        if (gq.size() == 2) begin
            chk("arb_first", gq[0], 0);
            chk("arb_second", gq[1], 1);
        end
        chk("arb_rdata0", 32'(d_rdata[0]), 32'h11);
        chk("arb_rdata1", 32'(d_rdata[1]), 32'h22);
        chk("arb_gnt1_cycle", g_cyc[1], 5);
        chk("arb_lat1", d_lat[1], 7);
        chk("arb_q", 32'(q), 32'h22);

        // Stuck cell, all retries exhausted
        set_op(0, 2'b01, 8'hFF, 8'h00);
        run(1, 0, 0);
        chk("clr_q", 32'(q), 32'h00);
        cell_stall = 8'h01;
        set_op(0, 2'b00, 8'hFF, 8'hFF);
        iss0 = m_issues;
        run(1, 0, 0);
        chk("stall_issues", n_issue, 4);
        chk("stall_model_issues", m_issues - iss0, 4);
        chk("stall_err", 32'(d_err[0]), 32'h1);
        chk("stall_rdata", 32'(d_rdata[0]), 32'hFE);
        chk("stall_lat", d_lat[0], 9);
        cell_stall = '0;

        // Stuck cell released during retry 2
        set_op(0, 2'b01, 8'hFF, 8'h00);
        run(1, 0, 0);
        cell_stall = 8'h01;
        set_op(0, 2'b00, 8'hFF, 8'hFF);
        run(1, 0, 3);
        chk("rel_issues", n_issue, 3);
        chk("rel_err", 32'(d_err[0]), 32'h0);
        chk("rel_rdata", 32'(d_rdata[0]), 32'hFF);
        chk("rel_lat", d_lat[0], 7);
        cell_stall = '0;

        // Partial-mask WRITE, then READ ignores mask
        set_op(1, 2'b00, 8'h0F, 8'h3C);
        run(0, 1, 0);
        chk("pw_rdata", 32'(d_rdata[1]), 32'hFC);
        set_op(0, 2'b11, 8'h0F, 8'h00);
        run(1, 0, 0);
        chk("rd_rdata", 32'(d_rdata[0]), 32'hFC);
        chk("rd_no_cn", n_issue, 0);
        chk("rd_lat", d_lat[0], 3);

        // Reset while in CHECK, then re-grant with req still high
        @(negedge clk);
        set_op(0, 2'b00, 8'hFF, 8'h5A);
        req0 = 1;
        @(negedge clk);
        chk("rc_gnt", 32'(gnt0), 32'h1);
        @(negedge clk);
        chk("rc_in_check_q", 32'(q), 32'h5A);
        #1 reset = 1;
        #1;
        chk("rc_q", 32'(q), 32'h00);
        chk("rc_busy", 32'(busy), 32'h0);
        chk("rc_cn_n", 32'(cn_n), 32'h00);
        repeat (2) begin
            @(negedge clk);
            chk("rc_no_done", 32'(done0), 32'h0);
            chk("rc_idle", 32'(busy), 32'h0);
        end
        #1 reset = 0;
        cyc = 0;
        seen = 0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (done0) begin
                seen = 1;
                req0 = 0;
                chk("rc_lat", cyc, 3);
                chk("rc_rdata", 32'(rdata), 32'h5A);
                chk("rc_err", 32'(err), 32'h0);
            end
        end
        if (!seen) begin
            chk("rc_timeout", 32'd1, 32'd0);
            req0 = 0;
        end
        repeat (3) @(negedge clk);
        chk("end_q", 32'(q), 32'h5A);
        chk("end_busy", 32'(busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cn_bank_ctrl.md
# cn_bank_ctrl

Sequencer and two-port arbiter for a WIDTH-bit bank of CN (change/no-change) cells. Each cell obeys the CN rule: N=0 holds, N=1 with C=0 clears, N=1 with C=1 toggles. The block owns the bank and shares it between two requesters using round-robin arbitration. It turns each WRITE/CLEAR/TOGGLE/READ request into per-bit C/N vectors, checks the result, retries on mismatch, and reports done/err.

## Interface
- WIDTH, 8, bits in the CN bank
- MAX_RETRY, 3, extra ISSUE attempts after a failed check (0..7)
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state and the bank
- req0, req1  in  1  level request; held high until the matching done pulse
- op0, op1  in  2  00 WRITE, 01 CLEAR, 10 TOGGLE, 11 READ
- mask0, mask1  in  WIDTH  bits affected by the op (ignored for READ)
- data0, data1  in  WIDTH  write data (WRITE only)
- cell_stall  in  WIDTH  test hook; a 1 forces that cell's effective N to 0 (cell ignores command)
- gnt0, gnt1  out  1  one-cycle pulse in the first ISSUE cycle of a granted op
- done0, done1  out  1  one-cycle completion pulse
- err  out  1  valid with done; 1 means target not reached after all retries
- rdata  out  WIDTH  bank value captured at completion; valid with done, holds until next done
- cn_c, cn_n  out  WIDTH  C/N vectors currently applied to the bank
- q  out  WIDTH  bank contents
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ISSUE, CHECK, RESP.
- IDLE: if any req is high, grant. Both high: grant the requester not served last. The priority pointer resets to favour req0. On grant:
  - latch requester id;
  - compute target from current q:
    - WRITE: (q & ~mask) | (data & mask)
    - CLEAR: q & ~mask
    - TOGGLE: q ^ mask
    - READ: q
  - clear the retry count;
  - go to ISSUE.
- ISSUE: for every bit, diff = q ^ target.
  - cn_n = diff; cn_c = diff & target. A 0→1 bit toggles; a 1→0 bit clears; equal bits hold.
  - Bank updates on the closing edge using effective N = cn_n & ~cell_stall.
  - Go to CHECK.
  - Because C/N are always recomputed from target, a retry never double-toggles.
- CHECK: cn_n = cn_c = 0.
  - q == target: go to RESP with err = 0.
  - Mismatch and retry count < MAX_RETRY: increment the count and return to ISSUE.
  - Otherwise: go to RESP with err = 1.
- RESP: pulse done of the latched requester, update rdata = q and err, then go to IDLE.
- Arbitration:
  - The pointer updates at grant.
  - A requester whose req is still high in the IDLE cycle after its done is served again as a new op. Requesters drop req on the edge after seeing done.
  - op/mask/data are sampled only at grant; later changes are ignored.
- Reset (any time, including mid-op):
  - q, cn_c, cn_n, rdata = 0; gnt*, done*, err, busy = 0;
  - state IDLE; pointer favours req0; the in-flight op is dropped with no done.

## Timing
- Edge E0 samples req in IDLE → ISSUE.
  - gnt, busy and the nonzero cn_n/cn_c are visible in the following cycle.
- E1: bank updates and q shows the new value; → CHECK.
- E2: compare → RESP; done/err/rdata visible for one cycle.
- E3: → IDLE. Minimum req-to-done latency is 3 edges; each retry adds 2 cycles.
- Back-to-back: the earliest next grant is at the edge after RESP (one IDLE cycle between ops).
- cn_n is nonzero only in ISSUE; never nonzero in IDLE, CHECK or RESP.
- Width rule: all vectors are WIDTH bits; the retry counter is 3 bits.

## Test plan
- Reset then WRITE from req0 with mask=FF, data=A5 (WIDTH=8):
  - gnt0 at cycle 1; cn_n=A5, cn_c=A5 in ISSUE;
  - q=A5 after E1; done0 at cycle 3 with rdata=A5, err=0.
- Starting from q=A5, TOGGLE mask=0F from req1 → q=AA, done1, err=0. Then CLEAR mask=F0 → q=0A.
- req0 and req1 high together, both WRITE with mask=FF (data 11 and 22):
  - req0 is served first, then req1;
  - final q=22; gnt pulses alternate 0 then 1.
- cell_stall=01 held, WRITE mask=FF data=FF from q=00 (MAX_RETRY=3):
  - 4 ISSUE cycles; done with err=1 and rdata=FE;
  - with stall released during retry 2, completes with err=0 and rdata=FF.
- Assert reset in CHECK of a WRITE → q=00, busy=0, no done pulse. With req still high after reset release, the op is re-granted and completes normally.
